instr_fetch: RTL and testbench



---
 rtl/instr_fetch.sv | 82 ++++++++
 tb/tb_instr_fetch.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC register, little-endian byte-addressed instruction
// memory with a word loader port, stall/redirect handling and the IF/ID flush.
module instr_fetch #(
  parameter int          IMEM_BYTES = 256,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        PCSrc,
  input  logic [63:0] Branch_target,
  input  logic        imem_we,
  input  logic [63:0] imem_waddr,
  input  logic [31:0] imem_wdata,
  output logic [63:0] PC_addr,
  output logic [31:0] Instruc,
  output logic        Flush,
  output logic [31:0] fetch_count
);

  localparam int          AW         = $clog2(IMEM_BYTES);
  localparam logic [63:0] IMEM_LIMIT = 64'(IMEM_BYTES);
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  logic [7:0]    mem_r [IMEM_BYTES];
  logic [63:0]   pc_r;
  logic [31:0]   count_r;
  logic [63:0]   tgt_s;
  logic [63:0]   waddr_s;
  logic [AW-1:0] ridx_s;
  logic [AW-1:0] widx_s;
  logic [31:0]   instr_s;

  // Targets and loader addresses are forced to word alignment.
  assign tgt_s   = Branch_target & ~64'h3;
  assign waddr_s = imem_waddr & ~64'h3;
  assign ridx_s  = pc_r[AW-1:0];
  assign widx_s  = waddr_s[AW-1:0];

  // PC and fetch counter: reset > redirect > hold > sequential advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r    <= RESET_PC;
      count_r <= 32'd0;
    end else if (PCSrc) begin
      pc_r    <= tgt_s;
      count_r <= count_r + 32'd1;
    end else if (PCWrite) begin
      pc_r    <= pc_r + 64'd4;
      count_r <= count_r + 32'd1;
    end
  end

  // Loader word write; memory is deliberately outside the reset domain
  always_ff @(posedge clk) begin
    if (imem_we && (waddr_s < IMEM_LIMIT)) begin
      mem_r[{widx_s[AW-1:2], 2'b00}] <= imem_wdata[7:0];
      mem_r[{widx_s[AW-1:2], 2'b01}] <= imem_wdata[15:8];
      mem_r[{widx_s[AW-1:2], 2'b10}] <= imem_wdata[23:16];
      mem_r[{widx_s[AW-1:2], 2'b11}] <= imem_wdata[31:24];
    end
  end

  // Combinational fetch; addresses past the memory return a NOP, never an alias
  always_comb begin
    instr_s = NOP_INSTR;
    if (pc_r < IMEM_LIMIT) begin
      instr_s = {mem_r[{ridx_s[AW-1:2], 2'b11}],
                 mem_r[{ridx_s[AW-1:2], 2'b10}],
                 mem_r[{ridx_s[AW-1:2], 2'b01}],
                 mem_r[{ridx_s[AW-1:2], 2'b00}]};
    end else begin
      instr_s = NOP_INSTR;
    end
  end

  assign PC_addr     = pc_r;
  assign Instruc     = instr_s;
  assign Flush       = PCSrc & ~reset;
  assign fetch_count = count_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, hand-written reset
// sequence, then randomized traffic against a behavioural fetch-stage model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        PCWrite = 1'b0;
  logic        PCSrc = 1'b0;
  logic [63:0] Branch_target = 64'h0;
  logic        imem_we = 1'b0;
  logic [63:0] imem_waddr = 64'h0;
  logic [31:0] imem_wdata = 32'h0;
  logic [63:0] PC_addr;
  logic [31:0] Instruc;
  logic        Flush;
  logic [31:0] fetch_count;

  int checks = 0;
  int failures = 0;

  instr_fetch #(.IMEM_BYTES(256), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .Branch_target(Branch_target), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .PC_addr(PC_addr), .Instruc(Instruc),
    .Flush(Flush), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: byte array, PC and count as plain numbers.
  byte unsigned    mem_m [256];
  longint unsigned pc_m;
  int unsigned     cnt_m;

  function automatic logic [31:0] model_instr(longint unsigned a);
    if (a >= 256) return 32'h0000_0013;
    return {mem_m[a+3], mem_m[a+2], mem_m[a+1], mem_m[a]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pcw, input logic src, input logic [63:0] tgt,
                       input logic we, input logic [63:0] wa, input logic [31:0] wd);
    PCWrite = pcw; PCSrc = src; Branch_target = tgt;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
  endtask

  // Apply the model's view of the coming edge, then take the edge.
  task automatic advance();
    longint unsigned a;
    if (imem_we) begin
      a = imem_waddr & ~64'h3;
      if (a < 256) begin
        mem_m[a]   = imem_wdata[7:0];
        mem_m[a+1] = imem_wdata[15:8];
        mem_m[a+2] = imem_wdata[23:16];
        mem_m[a+3] = imem_wdata[31:24];
      end
    end
    if (!reset) begin
      if (PCSrc) begin
        pc_m = Branch_target & ~64'h3;
        cnt_m++;
      end else if (PCWrite) begin
        pc_m = pc_m + 4;
        cnt_m++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] a, input logic [31:0] d);
    drive(1'b0, 1'b0, 64'h0, 1'b1, a, d);
    advance();
    imem_we = 1'b0;
  endtask

  typedef struct {
    logic        pcw;
    logic        src;
    logic [63:0] tgt;
    logic        we;
    logic [63:0] wa;
    logic [31:0] wd;
    logic [63:0] e_pc;
    logic [31:0] e_ins;
    logic        e_fl;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[20];

  initial begin
    longint unsigned tgt;
    foreach (mem_m[i]) mem_m[i] = 8'h00;
    pc_m = 0; cnt_m = 0;

    //            pcw   src   tgt      we    waddr    wdata         e_pc     e_ins         fl    cnt
    tbl[0]  = '{1'b1, 1'b0, 64'h0,   1'b0, 64'h0,   32'h0,        64'h0,   32'h00500093, 1'b0, 32'd0};
    tbl[1]  = '{1'b1, 1'b0, 64'h0,   1'b0, 64'h0,   32'h0,        64'h4,   32'h00A00113, 1'b0, 32'd1};
    tbl[2]  = '{1'b0, 1'b0, 64'h0,   1'b0, 64'h0,   32'h0,        64'h8,   32'h002081B3, 1'b0, 32'd2};
    tbl[3]  = '{1'b0, 1'b0, 64'h0,   1'b0, 64'h0,   32'h0,        64'h8,   32'h002081B3, 1'b0, 32'd2};
    tbl[4]  = '{1'b0, 1'b0, 64'h0,   1'b0, 64'h0,   32'h0,        64'h8,   32'h002081B3, 1'b0, 32'd2};
    tbl[5]  = '{1'b1, 1'b0, 64'h0,   1'b0, 64'h0,   32'h0,        64'h8,   32'h002081B3, 1'b0, 32'd2};
    tbl[6]  = '{1'b1, 1'b1, 64'h43,  1'b0, 64'h0,   32'h0,        64'hC,   32'h11111111, 1'b1, 32'd3};
    tbl[7]  = '{1'b1, 1'b0, 64'h0,   1'b0, 64'h0,   32'h0,        64'h40,  32'h22222222, 1'b0, 32'd4};
    tbl[8]  = '{1'b0, 1'b1, 64'h10,  1'b0, 64'h0,   32'h0,        64'h44,  32'h33333333, 1'b1, 32'd5};
    tbl[9]  = '{1'b0, 1'b0, 64'h0,   1'b0, 64'h0,   32'h0,        64'h10,  32'h44444444, 1'b0, 32'd6};
    tbl[10] = '{1'b1, 1'b1, 64'h100, 1'b0, 64'h0,   32'h0,        64'h10,  32'h44444444, 1'b1, 32'd6};
    tbl[11] = '{1'b0, 1'b0, 64'h0,   1'b1, 64'h100, 32'hDEADBEEF, 64'h100, 32'h00000013, 1'b0, 32'd7};
    tbl[12] = '{1'b0, 1'b0, 64'h0,   1'b1, 64'hE,   32'hCAFEF00D, 64'h100, 32'h00000013, 1'b0, 32'd7};
    tbl[13] = '{1'b0, 1'b1, 64'hC,   1'b0, 64'h0,   32'h0,        64'h100, 32'h00000013, 1'b1, 32'd7};
    tbl[14] = '{1'b0, 1'b0, 64'h0,   1'b1, 64'hC,   32'h55AA55AA, 64'hC,   32'hCAFEF00D, 1'b0, 32'd8};
    tbl[15] = '{1'b0, 1'b0, 64'h0,   1'b0, 64'h0,   32'h0,        64'hC,   32'h55AA55AA, 1'b0, 32'd8};
    tbl[16] = '{1'b0, 1'b1, 64'h0,   1'b0, 64'h0,   32'h0,        64'hC,   32'h55AA55AA, 1'b1, 32'd8};
    tbl[17] = '{1'b0, 1'b0, 64'h0,   1'b0, 64'h0,   32'h0,        64'h0,   32'h00500093, 1'b0, 32'd9};
    tbl[18] = '{1'b1, 1'b1, 64'h22,  1'b0, 64'h0,   32'h0,        64'h0,   32'h00500093, 1'b1, 32'd9};
    tbl[19] = '{1'b0, 1'b0, 64'h0,   1'b0, 64'h0,   32'h0,        64'h20,  32'h00000000, 1'b0, 32'd10};

    // Asynchronous reset, seen before any clock edge
    #1 reset = 1'b1;
    #1;
    check("reset_pc", PC_addr, 64'h0);
    check("reset_cnt", 64'(fetch_count), 64'h0);
    check("reset_flush", 64'(Flush), 64'h0);

    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) load(64'(i * 4), 32'h0);
    load(64'h0,  32'h00500093);
    load(64'h4,  32'h00A00113);
    load(64'h8,  32'h002081B3);
    load(64'hC,  32'h11111111);
    load(64'h40, 32'h22222222);
    load(64'h44, 32'h33333333);
    load(64'h10, 32'h44444444);
    check("reset_hold_pc", PC_addr, 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].pcw, tbl[i].src, tbl[i].tgt, tbl[i].we, tbl[i].wa, tbl[i].wd);
      #2;
      check($sformatf("vec%0d_pc", i), PC_addr, tbl[i].e_pc);
      check($sformatf("vec%0d_instr", i), 64'(Instruc), 64'(tbl[i].e_ins));
      check($sformatf("vec%0d_flush", i), 64'(Flush), 64'(tbl[i].e_fl));
      check($sformatf("vec%0d_cnt", i), 64'(fetch_count), 64'(tbl[i].e_cnt));
      advance();
    end

    // Reset asserted between edges while a redirect is pending
    drive(1'b1, 1'b1, 64'h30, 1'b0, 64'h0, 32'h0);
    #2 reset = 1'b1;
    #1;
    check("async_pc", PC_addr, 64'h0);
    check("async_cnt", 64'(fetch_count), 64'h0);
    check("async_flush", 64'(Flush), 64'h0);
    check("async_mem", 64'(Instruc), 64'h00500093);
    @(posedge clk); #1;
    check("async_hold_pc", PC_addr, 64'h0);
    drive(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
    reset = 1'b0;
    pc_m = 0; cnt_m = 0;
    advance();
    check("post_reset_pc", PC_addr, 64'h4);
    check("post_reset_cnt", 64'(fetch_count), 64'h1);
    check("post_reset_mem", 64'(Instruc), 64'h00A00113);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(19) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15));
      else tgt = 64'($urandom_range(300));
      drive(($urandom_range(3) != 0), ($urandom_range(6) == 0), tgt,
            ($urandom_range(4) == 0), 64'($urandom_range(300)), $urandom);
      #2;
      check("rnd_pc", PC_addr, pc_m);
      check("rnd_instr", 64'(Instruc), 64'(model_instr(pc_m)));
      check("rnd_flush", 64'(Flush), 64'(PCSrc));
      check("rnd_cnt", 64'(fetch_count), 64'(cnt_m));
      advance();
    end

    // Explicit 64-bit wrap of the sequential advance
    drive(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64'h0, 32'h0);
    advance();
    check("wrap_top", PC_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_nop", 64'(Instruc), 64'h00000013);
    drive(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
    advance();
    check("wrap_zero", PC_addr, 64'h0);
    check("wrap_cnt", 64'(fetch_count), 64'(cnt_m));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
